// File: rtl/mem_pkg.sv
// Shared types and helpers for the multi-channel memory.
package mem_pkg;

  localparam int BYTE = 8;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } acc_e;

  // One byte lane of a write: take the new byte when its enable is set.
  function automatic logic [BYTE-1:0] byte_merge(input logic [BYTE-1:0] old_b,
                                                 input logic [BYTE-1:0] new_b,
                                                 input logic            be_b);
    return be_b ? new_b : old_b;
  endfunction

endpackage

// File: rtl/multi_channel_memory_if.sv
// Requester-side bus of the multi-channel memory: per-channel request lanes plus shared read data.
interface multi_channel_memory_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_CH     = 2
);
  logic [NUM_CH-1:0]            valid;
  logic [NUM_CH-1:0]            ready;
  logic [NUM_CH-1:0]            wr_rd;
  logic [NUM_CH*ADDR_WIDTH-1:0] addr;
  logic [NUM_CH*WIDTH-1:0]      wdata;
  logic [NUM_CH*WIDTH/8-1:0]    be;
  logic [NUM_CH-1:0]            rvalid;
  logic [WIDTH-1:0]             rdata;
  logic [NUM_CH-1:0]            err;

  modport master (
    output valid, wr_rd, addr, wdata, be,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  valid, wr_rd, addr, wdata, be,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from ptr_q, ptr advances past each winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         res,
  input  logic [N-1:0] req_i,
  input  logic         upd_en_i,
  output logic [N-1:0] grant_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_s;
  logic          found_s;
  int            idx_s;
  int            nxt_s;

  // Grant search and next pointer.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    idx_s   = 0;
    nxt_s   = int'(ptr_q);
    for (int i = 0; i < N; i++) begin
      idx_s = (int'(ptr_q) + i) % N;
      if (!found_s && req_i[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        found_s        = 1'b1;
        nxt_s          = (idx_s + 1) % N;
      end else begin
        grant_s = grant_s;
      end
    end
    if (upd_en_i && found_s) begin
      ptr_d = PW'(nxt_s);
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign grant_o = res ? grant_s : '0;

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!res) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multi_channel_memory.sv
// Single-port RAM shared by NUM_CH requesters; one round-robin grant per cycle, reads return after one cycle.
module multi_channel_memory
  import mem_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_CH     = 2,
  parameter int CLR_ON_RES = 1
) (
  input logic clk,
  input logic res,
  multi_channel_memory_if.slave bus
);
  localparam int NBE = WIDTH / BYTE;
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]     grant_s, rvalid_s, err_s;
  logic                  accept_s, oor_s, wr_bit_s;
  acc_e                  sel_acc_s;
  logic [CW-1:0]         sel_ch_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [WIDTH-1:0]      sel_wdata_s, old_word_s, merged_s;
  logic [NBE-1:0]        sel_be_s;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_rd_q, pend_rd_d;
  logic                  pend_oor_q, pend_oor_d;
  logic [CW-1:0]         pend_ch_q, pend_ch_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk      (clk),
    .res      (res),
    .req_i    (bus.valid),
    .upd_en_i (accept_s),
    .grant_o  (grant_s)
  );

  assign accept_s  = |grant_s;
  assign bus.ready = grant_s;

  // AND-OR payload mux: the grant is one-hot, so OR-ing masked lanes selects the winner.
  always_comb begin
    sel_ch_s    = '0;
    wr_bit_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_be_s    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_ch_s    = sel_ch_s | (grant_s[c] ? CW'(c) : '0);
      wr_bit_s    = wr_bit_s | (grant_s[c] & bus.wr_rd[c]);
      sel_addr_s  = sel_addr_s | ({ADDR_WIDTH{grant_s[c]}} & bus.addr[c*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_wdata_s = sel_wdata_s | ({WIDTH{grant_s[c]}} & bus.wdata[c*WIDTH +: WIDTH]);
      sel_be_s    = sel_be_s | ({NBE{grant_s[c]}} & bus.be[c*NBE +: NBE]);
    end
  end

  assign sel_acc_s  = acc_e'(wr_bit_s);
  assign oor_s      = (int'(sel_addr_s) >= DEPTH);
  assign old_word_s = oor_s ? '0 : mem_q[sel_addr_s];

  // Byte-enable merge of the addressed word.
  always_comb begin
    merged_s = '0;
    for (int b = 0; b < NBE; b++) begin
      merged_s[b*BYTE +: BYTE] = byte_merge(old_word_s[b*BYTE +: BYTE],
                                            sel_wdata_s[b*BYTE +: BYTE], sel_be_s[b]);
    end
  end

  // Storage array, optionally zeroed while reset is held.
  always_ff @(posedge clk) begin
    if (!res) begin
      if (CLR_ON_RES != 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end
    end else if (accept_s && (sel_acc_s == WR) && !oor_s) begin
      mem_q[sel_addr_s] <= merged_s;
    end
  end

  // Pending-response next state; out-of-range reads return zero via old_word_s.
  always_comb begin
    pend_vld_d = accept_s;
    pend_rd_d  = (sel_acc_s == RD);
    pend_ch_d  = sel_ch_s;
    pend_oor_d = oor_s;
    if (accept_s && (sel_acc_s == RD)) begin
      rdata_d = old_word_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Pending-response register.
  always_ff @(posedge clk) begin
    if (!res) begin
      pend_vld_q <= 1'b0;
      pend_rd_q  <= 1'b0;
      pend_oor_q <= 1'b0;
      pend_ch_q  <= '0;
      rdata_q    <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_rd_q  <= pend_rd_d;
      pend_oor_q <= pend_oor_d;
      pend_ch_q  <= pend_ch_d;
      rdata_q    <= rdata_d;
    end
  end

  // Response pulses; masked by res so a read accepted just before reset never responds.
  always_comb begin
    rvalid_s = '0;
    err_s    = '0;
    if (res && pend_vld_q) begin
      rvalid_s[pend_ch_q] = pend_rd_q;
      err_s[pend_ch_q]    = pend_oor_q;
    end else begin
      rvalid_s = '0;
      err_s    = '0;
    end
  end

  assign bus.rvalid = rvalid_s;
  assign bus.err    = err_s;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_multi_channel_memory.sv
// Bench for multi_channel_memory: instance A (DEPTH=64) and instance B (DEPTH=48, out-of-range cases).
module tb_multi_channel_memory;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  multi_channel_memory_if #(.WIDTH(16), .ADDR_WIDTH(6), .NUM_CH(2)) ifa ();
  multi_channel_memory_if #(.WIDTH(16), .ADDR_WIDTH(6), .NUM_CH(2)) ifb ();

  logic [1:0]  valid_v [2];
  logic [1:0]  wr_v    [2];
  logic [11:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  be_v    [2];

  assign ifa.valid = valid_v[0];
  assign ifa.wr_rd = wr_v[0];
  assign ifa.addr  = addr_v[0];
  assign ifa.wdata = wdata_v[0];
  assign ifa.be    = be_v[0];
  assign ifb.valid = valid_v[1];
  assign ifb.wr_rd = wr_v[1];
  assign ifb.addr  = addr_v[1];
  assign ifb.wdata = wdata_v[1];
  assign ifb.be    = be_v[1];

  multi_channel_memory #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6), .NUM_CH(2), .CLR_ON_RES(1)) dut_a (
    .clk (clk), .res (res), .bus (ifa)
  );
  multi_channel_memory #(.WIDTH(16), .DEPTH(48), .ADDR_WIDTH(6), .NUM_CH(2), .CLR_ON_RES(1)) dut_b (
    .clk (clk), .res (res), .bus (ifb)
  );

  typedef struct {
    int          due;
    logic [1:0]  rv;
    logic [1:0]  er;
    logic [15:0] data;
    bit          chk;
  } exp_t;

  typedef struct {
    int          d;
    int          ch;
    bit          wr;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_data;
    bit          exp_err;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, ncyc);
    end
  endtask

  task automatic push(int d, exp_t e);
    if (d == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  // Scoreboard: an entry is due on an exact cycle, every other cycle must be silent.
  task automatic chk_dut(int d, logic [1:0] rv, logic [1:0] er, logic [15:0] rd);
    exp_t e;
    bit   has = 1'b0;
    if (d == 0) begin
      if (qa.size() > 0 && qa[0].due == ncyc) begin e = qa.pop_front(); has = 1'b1; end
    end else begin
      if (qb.size() > 0 && qb[0].due == ncyc) begin e = qb.pop_front(); has = 1'b1; end
    end
    if (has) begin
      check($sformatf("rvalid dut%0d", d), 32'(rv), 32'(e.rv));
      check($sformatf("err dut%0d", d), 32'(er), 32'(e.er));
      if (e.chk) check($sformatf("rdata dut%0d", d), 32'(rd), 32'(e.data));
    end else begin
      check($sformatf("idle rvalid/err dut%0d", d), 32'({rv, er}), 32'(0));
    end
  endtask

  always @(negedge clk) begin
    chk_dut(0, ifa.rvalid, ifa.err, ifa.rdata);
    chk_dut(1, ifb.rvalid, ifb.err, ifb.rdata);
  end

  function automatic vec_t mk(int d, int ch, bit wr, logic [5:0] a, logic [15:0] wd,
                              logic [1:0] be, logic [15:0] ed, bit ee);
    vec_t v;
    v.d = d; v.ch = ch; v.wr = wr; v.addr = a; v.wdata = wd;
    v.be = be; v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive_lane(int d, int ch, bit wr, logic [5:0] a, logic [15:0] wd, logic [1:0] be);
    wr_v[d][ch]             = wr;
    addr_v[d][ch*6 +: 6]    = a;
    wdata_v[d][ch*16 +: 16] = wd;
    be_v[d][ch*2 +: 2]      = be;
    valid_v[d][ch]          = 1'b1;
  endtask

  // Single uncontended transaction: ready must come in the same cycle.
  task automatic do_txn(vec_t v);
    logic [1:0] oh;
    logic [1:0] rdy;
    oh = 2'b01 << v.ch;
    @(posedge clk); #1;
    drive_lane(v.d, v.ch, v.wr, v.addr, v.wdata, v.be);
    @(negedge clk);
    rdy = (v.d == 0) ? ifa.ready : ifb.ready;
    check($sformatf("ready dut%0d ch%0d", v.d, v.ch), 32'(rdy), 32'(oh));
    if (rdy == oh && (!v.wr || v.exp_err)) begin
      push(v.d, '{due: ncyc + 1, rv: (v.wr ? 2'b00 : oh), er: (v.exp_err ? oh : 2'b00),
                 data: v.exp_data, chk: !v.wr});
    end
    @(posedge clk); #1;
    valid_v[v.d][v.ch] = 1'b0;
  endtask

  initial begin
    logic [1:0] want;
    res = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid_v[d] = 2'b00; wr_v[d] = 2'b00; addr_v[d] = 12'h000;
      wdata_v[d] = 32'h0; be_v[d] = 4'h0;
    end
    valid_v[0] = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready held in reset", 32'(ifa.ready), 32'(0));
    @(posedge clk); #1;
    res = 1'b1;
    valid_v[0] = 2'b00;
    @(negedge clk);
    check("ready idle after reset", 32'(ifa.ready), 32'(0));
    check("rdata after reset", 32'(ifa.rdata), 32'(0));

    // d, ch, wr, addr, wdata, be, expected rdata, expected err
    vecs.push_back(mk(0, 0, 1'b1, 6'd3,  16'h1234, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 0, 1'b1, 6'd3,  16'hABCD, 2'b10, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 0, 1'b0, 6'd3,  16'h0000, 2'b00, 16'hAB34, 1'b0));
    vecs.push_back(mk(0, 1, 1'b1, 6'd3,  16'hFF77, 2'b01, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1, 1'b0, 6'd3,  16'h0000, 2'b00, 16'hAB77, 1'b0));
    vecs.push_back(mk(0, 1, 1'b1, 6'd0,  16'h0001, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 0, 1'b1, 6'd0,  16'hFFFF, 2'b00, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 0, 1'b0, 6'd0,  16'h0000, 2'b00, 16'h0001, 1'b0));
    vecs.push_back(mk(0, 0, 1'b1, 6'd63, 16'hC3C3, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1, 1'b0, 6'd63, 16'h0000, 2'b00, 16'hC3C3, 1'b0));
    vecs.push_back(mk(1, 0, 1'b1, 6'd2,  16'h2222, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk(1, 0, 1'b1, 6'd47, 16'h7777, 2'b11, 16'h0000, 1'b0));
    vecs.push_back(mk(1, 1, 1'b0, 6'd50, 16'h0000, 2'b00, 16'h0000, 1'b1));
    vecs.push_back(mk(1, 0, 1'b1, 6'd50, 16'h9999, 2'b11, 16'h0000, 1'b1));
    vecs.push_back(mk(1, 1, 1'b0, 6'd2,  16'h0000, 2'b00, 16'h2222, 1'b0));
    vecs.push_back(mk(1, 0, 1'b0, 6'd47, 16'h0000, 2'b00, 16'h7777, 1'b0));
    vecs.push_back(mk(1, 0, 1'b0, 6'd18, 16'h0000, 2'b00, 16'h0000, 1'b0));
    vecs.push_back(mk(1, 1, 1'b0, 6'd63, 16'h0000, 2'b00, 16'h0000, 1'b1));
    for (int i = 0; i < vecs.size(); i++) do_txn(vecs[i]);

    // Read-after-write across channels: ch1 writes in T, ch0 reads in T+1.
    @(posedge clk); #1;
    drive_lane(0, 1, 1'b1, 6'd63, 16'h5A5A, 2'b11);
    @(negedge clk);
    check("raw write ready", 32'(ifa.ready), 32'(2'b10));
    @(posedge clk); #1;
    valid_v[0][1] = 1'b0;
    drive_lane(0, 0, 1'b0, 6'd63, 16'h0000, 2'b00);
    @(negedge clk);
    check("raw read ready", 32'(ifa.ready), 32'(2'b01));
    if (ifa.ready == 2'b01) push(0, '{due: ncyc + 1, rv: 2'b01, er: 2'b00, data: 16'h5A5A, chk: 1'b1});
    @(posedge clk); #1;
    valid_v[0][0] = 1'b0;

    // Clear-on-reset, then contention starting from ptr=0.
    do_txn(mk(0, 1, 1'b1, 6'd5, 16'hBEEF, 2'b11, 16'h0000, 1'b0));
    @(posedge clk); #1; res = 1'b0;
    @(posedge clk); #1; res = 1'b1;
    do_txn(mk(0, 1, 1'b1, 6'd10, 16'h1111, 2'b11, 16'h0000, 1'b0));
    do_txn(mk(0, 1, 1'b1, 6'd11, 16'h2222, 2'b11, 16'h0000, 1'b0));
    @(posedge clk); #1;
    drive_lane(0, 0, 1'b0, 6'd10, 16'h0000, 2'b00);
    drive_lane(0, 1, 1'b0, 6'd11, 16'h0000, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("contention ready %0d", i), 32'(ifa.ready), 32'(want));
      if (ifa.ready == want)
        push(0, '{due: ncyc + 1, rv: want, er: 2'b00,
                  data: ((i % 2 == 0) ? 16'h1111 : 16'h2222), chk: 1'b1});
      @(posedge clk);
    end
    #1;
    valid_v[0] = 2'b00;
    do_txn(mk(0, 0, 1'b0, 6'd5, 16'h0000, 2'b00, 16'h0000, 1'b0));

    // Reset right after a read is accepted: no response, ready low while reset holds.
    @(posedge clk); #1;
    drive_lane(0, 0, 1'b0, 6'd11, 16'h0000, 2'b00);
    @(negedge clk);
    check("mid-read accept", 32'(ifa.ready), 32'(2'b01));
    @(posedge clk); #1; res = 1'b0;
    @(negedge clk);
    check("ready in reset 1", 32'(ifa.ready), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("ready in reset 2", 32'(ifa.ready), 32'(0));
    @(posedge clk); #1;
    res = 1'b1;
    valid_v[0] = 2'b00;
    @(negedge clk);
    check("rdata cleared by reset", 32'(ifa.rdata), 32'(0));
    do_txn(mk(0, 0, 1'b0, 6'd10, 16'h0000, 2'b00, 16'h0000, 1'b0));

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(qa.size() + qb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
